// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator behind a two-entry elastic buffer.
// Define IMM_CSR_ZIMM_EN to decode type 7 as the zero-extended CSR uimm (ZIMM).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr_in,
  input  logic [2:0]       type_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             illegal_out
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_c;
  logic             ill_c;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_ill;
  logic             accept, consume, load_out;
  always_comb begin
    ill_c = 1'b0;
    case (type_in)
      3'd2:    imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      3'd3:    imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      3'd4:    imm32 = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      3'd5:    imm32 = {instr_in[31:12], 12'b0};
      3'd6:    imm32 = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
`ifdef IMM_CSR_ZIMM_EN
      3'd7:    imm32 = {27'b0, instr_in[19:15]};
`else
      3'd7: begin
        imm32 = '0;
        ill_c = 1'b1;
      end
`endif
      default: imm32 = '0;
    endcase
  end
  // Every 32-bit result is already sign-correct (ZIMM has bit 31 clear), so one sign extension covers XLEN=64.
  assign imm_c    = XLEN'($signed(imm32));
  assign in_ready = !skid_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign load_out = !out_valid || consume;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      skid_valid  <= 1'b0;
      imm_out     <= '0;
      tag_out     <= '0;
      illegal_out <= 1'b0;
      skid_imm    <= '0;
      skid_tag    <= '0;
      skid_ill    <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        skid_valid  <= 1'b0;
        imm_out     <= skid_imm;
        tag_out     <= skid_tag;
        illegal_out <= skid_ill;
      end else begin
        out_valid <= accept;
        if (accept) begin
          imm_out     <= imm_c;
          tag_out     <= tag_in;
          illegal_out <= ill_c;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= imm_c;
      skid_tag   <= tag_in;
      skid_ill   <= ill_c;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: checks XLEN=32 and XLEN=64 instances against a queue-based reference model.
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    bit          ill;
  } beat_t;
  typedef struct {
    logic [31:0] ins;
    logic [2:0]  t;
    logic [63:0] e64;
    bit          ill;
  } vec_t;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:7] instr_in = '0;
  logic [2:0]  type_in = '0;
  logic [4:0]  tag_in = '0;
  logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
  int checks = 0, errors = 0;
  beat_t q[$];
  logic [4:0] emitted[$];
  vec_t tbl[12];
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr_in(instr_in), .type_in(type_in), .tag_in(tag_in), .out_valid(ov32),
    .out_ready(out_ready), .imm_out(imm32), .tag_out(tag32), .illegal_out(ill32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr_in(instr_in), .type_in(type_in), .tag_in(tag_in), .out_valid(ov64),
    .out_ready(out_ready), .imm_out(imm64), .tag_out(tag64), .illegal_out(ill64));
  function automatic beat_t ref_beat(logic [31:0] x, logic [2:0] t, logic [4:0] tg);
    beat_t b;
    longint v = 0;
    b.ill = 0;
    case (t)
      3'd2: v = longint'($signed(x[31:20]));
      3'd3: v = longint'($signed({x[31:25], x[11:7]}));
      3'd4: v = longint'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
      3'd5: v = longint'($signed(x[31:12])) * 4096;
      3'd6: v = longint'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
`ifdef IMM_CSR_ZIMM_EN
      3'd7: v = longint'(x[19:15]);
`else
      3'd7: b.ill = 1;
`endif
      default: v = 0;
    endcase
    b.imm = v;
    b.tag = tg;
    return b;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_state();
    chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
    chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
    chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
    chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("imm32", 64'(imm32), 64'(q[0].imm[31:0]));
      chk("imm64", imm64, q[0].imm);
      chk("tag32", 64'(tag32), 64'(q[0].tag));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
      chk("ill32", 64'(ill32), 64'(q[0].ill));
      chk("ill64", 64'(ill64), 64'(q[0].ill));
    end
  endtask
  task automatic check_reset_outputs();
    chk("rst_in_ready", 64'({rdy32, rdy64}), 64'(0));
    chk("rst_out_valid", 64'({ov32, ov64}), 64'(0));
    chk("rst_imm32", 64'(imm32), 64'(0));
    chk("rst_imm64", imm64, 64'(0));
    chk("rst_tag", 64'({tag32, tag64}), 64'(0));
    chk("rst_ill", 64'({ill32, ill64}), 64'(0));
  endtask
  task automatic cycle(bit v, logic [31:0] ins, logic [2:0] t, logic [4:0] tg, bit ordy, bit fl);
    int  n;
    bit  acc, cons;
    in_valid  = v;
    instr_in  = ins[31:7];
    type_in   = t;
    tag_in    = tg;
    out_ready = ordy;
    flush     = fl;
    n    = q.size();
    acc  = v && n < 2 && !fl;
    cons = n > 0 && ordy && !fl;
    if (cons) emitted.push_back(q[0].tag);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(ref_beat(ins, t, tg));
    end
    check_state();
  endtask
  initial begin
    tbl[0]  = '{32'hFFF00093, 3'd2, 64'hFFFFFFFFFFFFFFFF, 0};
    tbl[1]  = '{32'hFE000EE3, 3'd4, 64'hFFFFFFFFFFFFFFFC, 0};
    tbl[2]  = '{32'h0080006F, 3'd6, 64'h0000000000000008, 0};
    tbl[3]  = '{32'hFE112E23, 3'd3, 64'hFFFFFFFFFFFFFFFC, 0};
    tbl[4]  = '{32'h123450B7, 3'd5, 64'h0000000012345000, 0};
    tbl[5]  = '{32'h80000037, 3'd5, 64'hFFFFFFFF80000000, 0};
    tbl[6]  = '{32'h7FF00093, 3'd2, 64'h00000000000007FF, 0};
`ifdef IMM_CSR_ZIMM_EN
    tbl[7]  = '{32'h000AD073, 3'd7, 64'h0000000000000015, 0};
`else
    tbl[7]  = '{32'h000AD073, 3'd7, 64'h0000000000000000, 1};
`endif
    tbl[8]  = '{32'hFFFFFFB3, 3'd1, 64'h0, 0};
    tbl[9]  = '{32'hFFFFFFFF, 3'd0, 64'h0, 0};
    tbl[10] = '{32'h800000EF, 3'd6, 64'hFFFFFFFFFFF00000, 0};
    tbl[11] = '{32'h80000063, 3'd4, 64'hFFFFFFFFFFFFF000, 0};
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1 check_state();
    for (int k = 0; k < 12; k++) begin
      cycle(1, tbl[k].ins, tbl[k].t, 5'(k), 1, 0);
      chk("vec_imm32", 64'(imm32), 64'(tbl[k].e64[31:0]));
      chk("vec_imm64", imm64, tbl[k].e64);
      chk("vec_ill", 64'({ill32, ill64}), {62'b0, tbl[k].ill, tbl[k].ill});
    end
    cycle(0, 0, 0, 0, 1, 0);
    emitted.delete();
    cycle(1, 32'h00100093, 3'd2, 5'd1, 0, 0);
    cycle(1, 32'h00200093, 3'd2, 5'd2, 0, 0);
    chk("bp_in_ready_full", 64'(rdy32), 64'(0));
    cycle(1, 32'h00300093, 3'd2, 5'd3, 0, 0);
    cycle(1, 32'h00300093, 3'd2, 5'd3, 1, 0);
    cycle(1, 32'h00300093, 3'd2, 5'd3, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("bp_count", 64'(emitted.size()), 64'(3));
    for (int k = 0; k < 3 && k < emitted.size(); k++) chk("bp_order", 64'(emitted[k]), 64'(k + 1));
    cycle(1, 32'h00400093, 3'd2, 5'd4, 0, 0);
    cycle(1, 32'h00500093, 3'd2, 5'd5, 0, 0);
    cycle(1, 32'h00900093, 3'd2, 5'd9, 1, 1);
    chk("flush_out_valid", 64'(ov32), 64'(0));
    chk("flush_in_ready", 64'(rdy32), 64'(1));
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 32'hFFF00093, 3'd2, 5'd6, 0, 0);
    cycle(1, 32'h123450B7, 3'd5, 5'd7, 0, 0);
    #2 rst = 1;
    #1 check_reset_outputs();
    q.delete();
    #1 rst = 0;
    #1 check_state();
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the combinational immediate generator in the decode stage. Accepts instruction bits [31:7] plus an immediate-type code through a valid/ready handshake, and produces the sign-extended XLEN-bit immediate one cycle later. A two-entry elastic buffer lets the ID stage absorb EX-stage stalls without a combinational ready path. A flush input supports branch/jump squashing.

## Interface
- `XLEN`, default 32: immediate width; legal values are 32 and 64, any other value is an elaboration error.
- `TAG_W`, default 5: width of the sideband tag (e.g. rd index) carried alongside each immediate.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous squash of all buffered entries.
- `in_valid` input 1: an upstream beat is present.
- `in_ready` output 1: the block can accept a beat this cycle.
- `instr_in` input [31:7]: instruction bits excluding the opcode.
- `type_in` input 3: immediate type (encoding below).
- `tag_in` input TAG_W: sideband tag, passed through unchanged.
- `out_valid` output 1: `imm_out`, `tag_out` and `illegal_out` are valid.
- `out_ready` input 1: downstream consumes the beat.
- `imm_out` output XLEN: generated immediate.
- `tag_out` output TAG_W: tag of the beat on `imm_out`.
- `illegal_out` output 1: the type code was unsupported.

## Operation
Type encoding:
- 0 NOTYPE and 1 RTYPE: immediate 0.
- 2 ITYPE: sext(In[31:20]).
- 3 STYPE: sext({In[31:25], In[11:7]}).
- 4 BTYPE: sext({In[31], In[7], In[30:25], In[11:8], 0}).
- 5 UTYPE: sext({In[31:12], 12'b0}).
- 6 JTYPE: sext({In[31], In[19:12], In[20], In[30:21], 0}).
- 7: see Configuration.

Arithmetic rules:
- sext replicates In[31] up to XLEN. For XLEN=64 this includes UTYPE, so LUI/AUIPC immediates are sign-extended.
- `imm_out` never carries X. Unsupported types produce 0 with `illegal_out`=1.

Buffering:
- Two stages: an output register (`out_valid`) and a skid register (`skid_valid`).
- `in_ready` = !`skid_valid` && !`rst`. It is registered, with no combinational path from `out_ready`.
- Accept: `in_valid` && `in_ready`. The immediate is computed combinationally at the input and stored already formatted.
- Output register empty, or being consumed this cycle: the beat goes to the output register. Otherwise it goes to the skid register.
- On consume (`out_valid` && `out_ready`) with the skid register full: skid moves to the output and `skid_valid` clears.
- Order is strictly FIFO.
- Outputs hold stable while `out_valid` && !`out_ready`.

Flush:
- Clears `out_valid` and `skid_valid` at the next edge.
- An input beat presented in the flush cycle is dropped.
- Flush has priority over accept and consume.

## Timing
- Latency: accept in cycle N gives `out_valid` in cycle N+1 if the output register was empty.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `skid_valid`=0, `imm_out`=0, `tag_out`=0, `illegal_out`=0. `in_ready`=0 while `rst` is high and 1 from the first cycle after release.
- Reset mid-transfer discards both entries immediately (asynchronous). Nothing is replayed.
- Simultaneous accept and consume with the skid register empty: the new beat replaces the output, and `out_valid` stays 1.
- Both entries full: `in_ready`=0 from the cycle after the second accept until a consume occurs.

## Configuration
- `IMM_CSR_ZIMM_EN` defined: type 7 = ZIMM. The result is zero-extended In[19:15] (the CSR uimm), with `illegal_out`=0.
- `IMM_CSR_ZIMM_EN` undefined: type 7 yields `imm_out`=0 and `illegal_out`=1.

## Test plan
- XLEN=32, ITYPE, instr 0xFFF00093, `out_ready`=1 -> next cycle `imm_out`=0xFFFFFFFF, `out_valid`=1, `illegal_out`=0.
- BTYPE with 0xFE000EE3 -> 0xFFFFFFFC. JTYPE with 0x0080006F -> 0x00000008. STYPE with 0xFE112E23 -> 0xFFFFFFFC. UTYPE with 0x123450B7 -> 0x12345000.
- XLEN=64, UTYPE with 0x80000037 -> 0xFFFFFFFF80000000. ITYPE with 0x7FF00093 -> 0x00000000000007FF.
- Backpressure: `in_valid`=1 with tags 1,2,3,… and `out_ready`=0 for 3 cycles. Expect 2 beats accepted, `in_ready`=0 from the cycle after the second accept, then tags 1,2,3 emitted in order once `out_ready`=1, with no loss or duplication.
- Flush with both entries full, plus `in_valid`=1 in the same cycle -> next cycle `out_valid`=0 and `in_ready`=1, and the dropped beat never appears. Async `rst` pulse mid-stream -> all outputs return to reset values within the same cycle.
- Type 7 with instr 0x000AD073 (uimm=0x15): with `IMM_CSR_ZIMM_EN` -> `imm_out`=0x15, `illegal_out`=0. Without it -> `imm_out`=0, `illegal_out`=1.
